// File: rtl/imem_loader.sv
// Instruction memory loader: receives a length-prefixed little-endian byte stream,
// writes 32-bit words into instruction memory and holds the core in reset until the
// load completes. Optional trailing XOR checksum enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        rx_ready_o,
  input  logic        reload_i,
  output logic        imem_we_o,
  output logic [31:0] imem_addr_o,
  output logic [31:0] imem_wdata_o,
  output logic        core_rst_o,
  output logic        done_o,
  output logic        error_o
);

  localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {StLenLo, StLenHi, StData, StCsum, StDone, StError} state_e;
`else
  typedef enum logic [2:0] {StLenLo, StLenHi, StData, StDone, StError} state_e;
`endif

  state_e            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [IdxW-1:0]   word_idx_q, word_idx_d;
  logic [23:0]       buf_q, buf_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              core_rst_q, core_rst_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic        accept;
  logic [15:0] len_full;
  logic        last_word;

  assign accept    = rx_valid_i & rx_ready_o;
  assign len_full  = {rx_data_i, len_q[7:0]};
  assign last_word = (32'(word_idx_q) + 32'd1) == {16'd0, len_q};

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StLenLo;
      len_q      <= '0;
      byte_cnt_q <= '0;
      word_idx_q <= '0;
      buf_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= BASE_ADDR;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      core_rst_q <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      byte_cnt_q <= byte_cnt_d;
      word_idx_q <= word_idx_d;
      buf_q      <= buf_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
      error_q    <= error_d;
      core_rst_q <= core_rst_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  // Next-state and datapath update on each accepted byte
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    word_idx_d = word_idx_q;
    buf_d      = buf_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    unique case (state_q)
      StLenLo: begin
        if (accept) begin
          len_d[7:0] = rx_data_i;
          state_d    = StLenHi;
        end
      end
      StLenHi: begin
        if (accept) begin
          len_d      = len_full;
          byte_cnt_d = '0;
          word_idx_d = '0;
          if (32'(len_full) > DEPTH_WORDS) begin
            state_d = StError;
          end else if (len_full == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = StCsum;
`else
            state_d = StDone;
`endif
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (accept) begin
          if (byte_cnt_q == 2'd3) begin
            we_d       = 1'b1;
            wdata_d    = {rx_data_i, buf_q};
            addr_d     = BASE_ADDR + (32'(word_idx_q) << 2);
            byte_cnt_d = '0;
            if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_d = StCsum;
`else
              state_d = StDone;
`endif
            end else begin
              // Only advanced when another word follows, so it stays below DEPTH_WORDS
              word_idx_d = word_idx_q + IdxW'(1);
            end
          end else begin
            buf_d[{byte_cnt_q, 3'b000} +: 8] = rx_data_i;
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      StCsum: begin
        if (accept) begin
          state_d = (rx_data_i == csum_q) ? StDone : StError;
        end
      end
`endif
      StDone, StError: begin
        if (reload_i) begin
          state_d    = StLenLo;
          word_idx_d = '0;
          byte_cnt_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d     = '0;
`endif
        end
      end
      default: state_d = StLenLo;
    endcase
`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running XOR over every byte except the checksum byte itself
    if (accept && (state_q != StCsum)) begin
      csum_d = csum_q ^ rx_data_i;
    end
`endif
  end

  // Handshake and registered status next values
  always_comb begin
    rx_ready_o = (state_q != StDone) && (state_q != StError);
    // Status follows the state one cycle late but drops with the reload edge itself
    done_d     = (state_q == StDone) && (state_d == StDone);
    error_d    = (state_q == StError) && (state_d == StError);
    core_rst_d = ~done_d;
  end

  assign imem_we_o    = we_q;
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;
  assign done_o       = done_q;
  assign error_o      = error_q;
  assign core_rst_o   = core_rst_q;

endmodule
